// File: rtl/sorted_vec_drain.sv
// sorted_vec_drain: captures whole sorted vectors from a non-stallable sorter,
// buffers them in a vector FIFO and streams them out one element per cycle
// (index 0 first) on a valid/ready interface, flagging the last element.
// Optional feature macro: SORTED_VEC_DRAIN_STATS_EN adds the saturating
// 16-bit dropped-vector counter on drop_cnt_o.
module sorted_vec_drain #(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned DATALENGTH = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          vec_valid_i,
  input  logic [DATAWIDTH-1:0]          vec_i [DATALENGTH-1:0],
  output logic                          elem_valid_o,
  input  logic                          elem_ready_i,
  output logic [DATAWIDTH-1:0]          elem_o,
  output logic [$clog2(DATALENGTH)-1:0] elem_idx_o,
  output logic                          elem_last_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          overflow_o
`ifdef SORTED_VEC_DRAIN_STATS_EN
  ,
  output logic [15:0]                   drop_cnt_o
`endif
);

  localparam int unsigned IW = $clog2(DATALENGTH);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATAWIDTH-1:0] mem_q [DEPTH][DATALENGTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          overflow_q, overflow_d;
`ifdef SORTED_VEC_DRAIN_STATS_EN
  logic [15:0]   drop_cnt_q, drop_cnt_d;
`endif

  logic empty_c, full_c, hs_c, last_c, pop_c, wr_en_c, drop_c;

  // Occupancy flags and handshake/write/drop qualifiers from current state
  always_comb begin
    empty_c = (wr_ptr_q == rd_ptr_q);
    full_c  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    last_c  = (idx_q == IW'(DATALENGTH - 1));
    hs_c    = !empty_c && elem_ready_i;
    pop_c   = hs_c && last_c;
    // A pop in the same cycle frees the slot the incoming vector needs
    wr_en_c = vec_valid_i && (!full_c || pop_c);
    drop_c  = vec_valid_i && full_c && !pop_c;
  end

  // Next-state for pointers, element index and overflow tracking
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    if (wr_en_c) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (hs_c) begin
      if (last_c) begin
        idx_d    = '0;
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
    if (drop_c) begin
      overflow_d = 1'b1;
    end
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Vector storage; contents survive reset, only the pointers are cleared
  always_ff @(posedge clk_i) begin
    if (wr_en_c) begin
      for (int unsigned i = 0; i < DATALENGTH; i++) begin
        mem_q[wr_ptr_q[AW-1:0]][i] <= vec_i[i];
      end
    end
  end

`ifdef SORTED_VEC_DRAIN_STATS_EN
  // Saturating dropped-vector counter
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_c && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Dropped-vector counter register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  // Output stream; element forced to zero while empty so stale storage never shows
  always_comb begin
    elem_valid_o = !empty_c;
    elem_o       = empty_c ? '0 : mem_q[rd_ptr_q[AW-1:0]][idx_q];
    elem_idx_o   = idx_q;
    elem_last_o  = last_c;
    full_o       = full_c;
    empty_o      = empty_c;
    overflow_o   = overflow_q;
  end

endmodule

// File: tb/tb_sorted_vec_drain.sv
// Directed self-checking bench for sorted_vec_drain (DATAWIDTH=8, DATALENGTH=4, DEPTH=4).
module tb_sorted_vec_drain;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       vec_valid_i;
  logic [7:0] vec_i [3:0];
  logic       elem_valid_o;
  logic       elem_ready_i;
  logic [7:0] elem_o;
  logic [1:0] elem_idx_o;
  logic       elem_last_o;
  logic       full_o;
  logic       empty_o;
  logic       overflow_o;
`ifdef SORTED_VEC_DRAIN_STATS_EN
  logic [15:0] drop_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  sorted_vec_drain #(.DATAWIDTH(8), .DATALENGTH(4), .DEPTH(4)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .vec_valid_i  (vec_valid_i),
    .vec_i        (vec_i),
    .elem_valid_o (elem_valid_o),
    .elem_ready_i (elem_ready_i),
    .elem_o       (elem_o),
    .elem_idx_o   (elem_idx_o),
    .elem_last_o  (elem_last_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .overflow_o   (overflow_o)
`ifdef SORTED_VEC_DRAIN_STATS_EN
    ,
    .drop_cnt_o   (drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] val(input int k, input int i);
    return 8'((k << 2) | i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_vec(input int k);
    for (int i = 0; i < 4; i++) vec_i[i] = val(k, i);
  endtask

  task automatic chk_elem(input string tag, input logic [7:0] v, input int i);
    chk({tag, "_valid"}, 32'(elem_valid_o), 32'd1);
    chk({tag, "_data"},  32'(elem_o), 32'(v));
    chk({tag, "_idx"},   32'(elem_idx_o), 32'(i));
    chk({tag, "_last"},  32'(elem_last_o), 32'(i == 3));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(elem_valid_o), 32'd0);
    chk({tag, "_data"},  32'(elem_o), 32'd0);
    chk({tag, "_idx"},   32'(elem_idx_o), 32'd0);
    chk({tag, "_last"},  32'(elem_last_o), 32'd0);
    chk({tag, "_full"},  32'(full_o), 32'd0);
    chk({tag, "_empty"}, 32'(empty_o), 32'd1);
    chk({tag, "_ovf"},   32'(overflow_o), 32'd0);
`ifdef SORTED_VEC_DRAIN_STATS_EN
    chk({tag, "_dcnt"},  32'(drop_cnt_o), 32'd0);
`endif
  endtask

  task automatic chk_drop(input string tag, input int exp);
`ifdef SORTED_VEC_DRAIN_STATS_EN
    chk(tag, 32'(drop_cnt_o), 32'(exp));
`else
    if (exp < 0) $display("unused %s", tag);
`endif
  endtask

  initial begin
    rstn_i       = 1'b0;
    vec_valid_i  = 1'b0;
    elem_ready_i = 1'b0;
    set_vec(0);
    #3;
    chk_reset("rst");
    #10 rstn_i = 1'b1;
    step();

    // Single vector, ready held high
    elem_ready_i = 1'b1;
    vec_valid_i  = 1'b1;
    vec_i[0] = 8'h90; vec_i[1] = 8'h50; vec_i[2] = 8'h20; vec_i[3] = 8'h05;
    step();
    vec_valid_i = 1'b0;
    chk("single_empty0", 32'(empty_o), 32'd0);
    chk_elem("single0", 8'h90, 0);
    step(); chk_elem("single1", 8'h50, 1);
    step(); chk_elem("single2", 8'h20, 2);
    step(); chk_elem("single3", 8'h05, 3);
    step();
    chk("single_empty", 32'(empty_o), 32'd1);
    chk("single_valid", 32'(elem_valid_o), 32'd0);

    // Ready toggling: stalled outputs hold, no skip or duplicate
    vec_valid_i = 1'b1; set_vec(5);
    step();
    vec_valid_i = 1'b0;
    chk_elem("stall_a", val(5, 0), 0);
    elem_ready_i = 1'b0;
    step(); chk_elem("stall_b", val(5, 0), 0);
    step(); chk_elem("stall_c", val(5, 0), 0);
    elem_ready_i = 1'b1;
    step(); chk_elem("stall_d", val(5, 1), 1);
    elem_ready_i = 1'b0;
    step(); chk_elem("stall_e", val(5, 1), 1);
    elem_ready_i = 1'b1;
    step(); chk_elem("stall_f", val(5, 2), 2);
    step(); chk_elem("stall_g", val(5, 3), 3);
    step();
    chk("stall_empty", 32'(empty_o), 32'd1);

    // Ten back-to-back vectors, one push every 4 cycles, across pointer wrap
    for (int k = 30; k < 40; k++) begin
      for (int i = 0; i < 4; i++) begin
        vec_valid_i = (i == 0);
        set_vec(k);
        step();
        vec_valid_i = 1'b0;
        chk_elem("stream", val(k, i), i);
        chk("stream_ovf", 32'(overflow_o), 32'd0);
      end
    end
    step();
    chk("stream_empty", 32'(empty_o), 32'd1);
    chk("stream_ovf_end", 32'(overflow_o), 32'd0);

    // Fill with consumer stalled; fifth vector is dropped
    elem_ready_i = 1'b0;
    for (int k = 10; k < 15; k++) begin
      vec_valid_i = 1'b1;
      set_vec(k);
      step();
      if (k == 12) chk("fill3_full", 32'(full_o), 32'd0);
      if (k == 13) begin
        chk("fill4_full", 32'(full_o), 32'd1);
        chk("fill4_ovf", 32'(overflow_o), 32'd0);
      end
    end
    vec_valid_i = 1'b0;
    chk("drop_full", 32'(full_o), 32'd1);
    chk("drop_ovf", 32'(overflow_o), 32'd1);
    chk_drop("drop_cnt", 1);
    chk_elem("drop_head", val(10, 0), 0);
    elem_ready_i = 1'b1;
    for (int k = 10; k < 14; k++) begin
      for (int i = 0; i < 4; i++) begin
        chk_elem("drain", val(k, i), i);
        step();
      end
    end
    chk("drain_empty", 32'(empty_o), 32'd1);
    chk("drain_ovf_sticky", 32'(overflow_o), 32'd1);

    // Full FIFO: write in the same cycle as a last-element handshake
    elem_ready_i = 1'b0;
    for (int k = 20; k < 24; k++) begin
      vec_valid_i = 1'b1;
      set_vec(k);
      step();
    end
    vec_valid_i = 1'b0;
    chk("wp_full", 32'(full_o), 32'd1);
    elem_ready_i = 1'b1;
    chk_elem("wp_h0", val(20, 0), 0);
    step(); chk_elem("wp_h1", val(20, 1), 1);
    step(); chk_elem("wp_h2", val(20, 2), 2);
    step(); chk_elem("wp_h3", val(20, 3), 3);
    vec_valid_i = 1'b1; set_vec(24);
    step();
    vec_valid_i = 1'b0;
    chk("wp_full_after", 32'(full_o), 32'd1);
    chk_drop("wp_dcnt", 1);
    for (int k = 21; k < 25; k++) begin
      for (int i = 0; i < 4; i++) begin
        chk_elem("wp_drain", val(k, i), i);
        step();
      end
    end
    chk("wp_empty", 32'(empty_o), 32'd1);

    // Asynchronous reset mid-vector at idx 2
    vec_valid_i = 1'b1; set_vec(40);
    step();
    vec_valid_i = 1'b0;
    step();
    step();
    chk_elem("mid_pre", val(40, 2), 2);
    #2 rstn_i = 1'b0;
    #1;
    chk_reset("mid_rst");
    #2 rstn_i = 1'b1;
    step();
    chk("mid_empty", 32'(empty_o), 32'd1);
    vec_valid_i = 1'b1; set_vec(41);
    step();
    vec_valid_i = 1'b0;
    chk_elem("mid_next", val(41, 0), 0);
    step(); chk_elem("mid_next1", val(41, 1), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
